// File: rtl/pulse_generator.sv
// Emits exactly cnt_q evenly spaced single-cycle pulses per WINDOW-cycle window.
// Spacing comes from a Bresenham accumulator, so no divider is needed.
module pulse_generator #(
    parameter int WINDOW = 200_000_000,
    parameter int CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             pulse_o,
    output logic             win_o,
    output logic [CNT_W-1:0] emitted_o,
    output logic             busy_o
);

    localparam int TIM_W = $clog2(WINDOW);
    localparam int ACC_W = TIM_W + 1;
    localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(WINDOW - 1);
    localparam logic [ACC_W-1:0] WIN_ACC  = ACC_W'(WINDOW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [TIM_W-1:0] tim_q, tim_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pul_cnt_q, pul_cnt_d;
    logic [CNT_W-1:0] emitted_q, emitted_d;
    logic             pulse_q, pulse_d;
    logic             win_q, win_d;

    logic [ACC_W-1:0] sum;
    logic             fire;
    logic             last;

    // acc < WINDOW and cnt_q < WINDOW, so the sum always fits in ACC_W bits.
    assign sum  = acc_q + ACC_W'(cnt_q);
    assign fire = (sum >= WIN_ACC);
    assign last = (tim_q == TIM_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        tim_d     = tim_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        pul_cnt_d = pul_cnt_q;
        emitted_d = emitted_q;
        pulse_d   = 1'b0;
        win_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d   = RUN;
                    cnt_d     = count_i;
                    acc_d     = '0;
                    tim_d     = '0;
                    pul_cnt_d = '0;
                end
            end
            RUN, STOP: begin
                if (fire) begin
                    acc_d     = sum - WIN_ACC;
                    pulse_d   = 1'b1;
                    pul_cnt_d = pul_cnt_q + CNT_W'(1);
                end else begin
                    acc_d = sum;
                end

                if (last) begin
                    // A window never gets cut short; the run request only decides what follows it.
                    win_d     = 1'b1;
                    emitted_d = pul_cnt_q + CNT_W'(fire);
                    tim_d     = '0;
                    pul_cnt_d = '0;
                    if (en_i) begin
                        state_d = RUN;
                        cnt_d   = count_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tim_d   = tim_q + TIM_W'(1);
                    state_d = en_i ? RUN : STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q   <= IDLE;
            tim_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            pul_cnt_q <= '0;
            emitted_q <= '0;
            pulse_q   <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tim_q     <= tim_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pul_cnt_q <= pul_cnt_d;
            emitted_q <= emitted_d;
            pulse_q   <= pulse_d;
            win_q     <= win_d;
        end
    end

    assign pulse_o   = pulse_q;
    assign win_o     = win_q;
    assign emitted_o = emitted_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator with WINDOW=10: a floor-arithmetic window model checked
// every cycle, plus directed literal expectations that pin the model.
module tb_pulse_generator;

    localparam int WINDOW = 10;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] count;
    logic             pulse;
    logic             win;
    logic [CNT_W-1:0] emitted;
    logic             busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    pulse_generator #(
        .WINDOW(WINDOW),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .count_i  (count),
        .pulse_o  (pulse),
        .win_o    (win),
        .emitted_o(emitted),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: in window cycle k with count c, a pulse is due when floor(k*c/W) steps up;
    // it appears one cycle later. A completed window always reports c pulses.
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_c      = 0;
    bit exp_pulse   = 1'b0;
    bit exp_win     = 1'b0;
    int exp_emitted = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active    = 1'b0;
            exp_pulse   = 1'b0;
            exp_win     = 1'b0;
            exp_emitted = 0;
        end else if (!m_active) begin
            exp_pulse = 1'b0;
            exp_win   = 1'b0;
            if (en) begin
                m_active = 1'b1;
                m_k      = 1;
                m_c      = int'(count);
            end
        end else begin
            exp_pulse = ((m_k * m_c) / WINDOW) != (((m_k - 1) * m_c) / WINDOW);
            if (m_k == WINDOW) begin
                exp_win     = 1'b1;
                exp_emitted = m_c;
                if (en) begin
                    m_k = 1;
                    m_c = int'(count);
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                exp_win = 1'b0;
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pulse", 32'(pulse), 32'(exp_pulse));
            check("model_win", 32'(win), 32'(exp_win));
            check("model_busy", 32'(busy), 32'(m_active));
            check("model_emitted", 32'(emitted), 32'(exp_emitted));
        end
    end

    initial begin
        logic [WINDOW-1:0] vec;
        logic [WINDOW-1:0] exp_vec;
        exp_vec = 10'b10_1001_0100;
        vec     = '0;

        rst = 1'b1; en = 1'b0; count = '0;
        wait_cyc(2);
        check("rst_pulse", 32'(pulse), 32'd0);
        check("rst_win", 32'(win), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_emitted", 32'(emitted), 32'd0);
        cmp_en = 1'b1;
        rst = 1'b0;
        wait_cyc(1);
        check("idle_busy", 32'(busy), 32'd0);

        // Nominal count=4: pulses after window cycles 3,5,8,10.
        en = 1'b1; count = 8'd4;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) check("nom_busy", 32'(busy), 32'd1);
            if (i >= 2) vec[i-2] = pulse;
        end
        check("nom_pattern", 32'(vec), 32'(exp_vec));
        check("nom_win", 32'(win), 32'd1);
        check("nom_emitted", 32'(emitted), 32'd4);

        // count 4->7 at window cycle 5 takes effect only in the following window.
        wait_cyc(4);
        count = 8'd7;
        wait_cyc(6);
        check("chg_cur_emitted", 32'(emitted), 32'd4);
        check("chg_cur_win", 32'(win), 32'd1);
        wait_cyc(10);
        check("chg_next_emitted", 32'(emitted), 32'd7);

        // count=9: nothing after window cycle 1, pulse after cycle 2, gapless windows.
        count = 8'd9;
        wait_cyc(10);
        check("c9_prev_emitted", 32'(emitted), 32'd7);
        wait_cyc(1);
        check("c9_k1_pulse", 32'(pulse), 32'd0);
        wait_cyc(1);
        check("c9_k2_pulse", 32'(pulse), 32'd1);
        wait_cyc(8);
        check("c9_emitted", 32'(emitted), 32'd9);
        check("c9_win", 32'(win), 32'd1);

        // count=0: windows keep running, no pulses.
        count = 8'd0;
        wait_cyc(10);
        check("c0_prev_emitted", 32'(emitted), 32'd9);
        wait_cyc(10);
        check("c0_emitted", 32'(emitted), 32'd0);
        check("c0_win", 32'(win), 32'd1);

        // en_i drops at window cycle 4: window completes, then IDLE.
        count = 8'd4;
        wait_cyc(10);
        wait_cyc(3);
        en = 1'b0;
        wait_cyc(6);
        check("stop_busy_k10", 32'(busy), 32'd1);
        wait_cyc(1);
        check("stop_busy_after", 32'(busy), 32'd0);
        check("stop_win", 32'(win), 32'd1);
        check("stop_emitted", 32'(emitted), 32'd4);
        wait_cyc(1);
        check("idle_win", 32'(win), 32'd0);
        check("idle_pulse", 32'(pulse), 32'd0);
        check("idle_hold_emitted", 32'(emitted), 32'd4);

        // STOP -> RUN mid-window leaves the window undisturbed.
        en = 1'b1; count = 8'd3;
        wait_cyc(1);
        wait_cyc(2);
        en = 1'b0;
        wait_cyc(3);
        en = 1'b1;
        wait_cyc(5);
        check("resume_win", 32'(win), 32'd1);
        check("resume_emitted", 32'(emitted), 32'd3);
        check("resume_busy", 32'(busy), 32'd1);

        // Reset at window cycle 6 discards the partial window.
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(1);
        check("mrst_pulse", 32'(pulse), 32'd0);
        check("mrst_win", 32'(win), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_emitted", 32'(emitted), 32'd0);
        rst = 1'b0; count = 8'd4;
        wait_cyc(11);
        check("restart_win", 32'(win), 32'd1);
        check("restart_emitted", 32'(emitted), 32'd4);

        en = 1'b0;
        wait_cyc(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
